// File: rtl/gigabit_egress_fifo.sv
// Egress store-and-forward frame buffer: 64-bit AXI4-Stream in, 32-bit AXI4-Stream out.
// Define EGRESS_FIFO_DROP_COUNT_EN to enable the saturating dropped-frame counter.
module gigabit_egress_fifo #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic [31:0] drop_count
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int PW = ADDR_BITS + 1;
    localparam logic [PW-1:0] FULL_DIFF = PW'(DEPTH);
    localparam logic [PW-1:0] ONE = PW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_HI   = 2'd3;

    logic [71:0]   r_mem [DEPTH];
    logic [71:0]   r_ram_q;
    logic [71:0]   r_word;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_wr_ptr_c;
    logic [PW-1:0] r_rd_ptr;
    logic          r_drop;
    logic          r_rdy;
    logic [1:0]    r_state;

    logic [3:0]    w_cnt;
    logic [3:0]    w_bm1;
    logic [71:0]   w_wdata;
    logic          w_acc;
    logic          w_full;
    logic          w_bad;
    logic          w_we;
    logic          w_rd_issue;
    logic [3:0]    w_rbm1;
    logic          w_rlast;
    logic          w_hi_need;
    logic          w_unused;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_cnt = w_cnt + {3'b000, s_tkeep[i]};
        end
    end

    assign w_bm1   = w_cnt - 4'd1;
    assign w_wdata = {3'b000, s_tlast, w_bm1, s_tdata};

    assign s_tready   = r_rdy;
    assign w_acc      = s_tvalid && r_rdy;
    // Wrap-safe occupancy test on the extra pointer bit
    assign w_full     = (r_wr_ptr - r_rd_ptr) == FULL_DIFF;
    assign w_bad      = r_drop || w_full || (s_tkeep == 8'h00);
    assign w_we       = w_acc && !w_bad;
    assign w_rd_issue = (r_state == S_IDLE) && (r_rd_ptr != r_wr_ptr_c);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= w_wdata;
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy      <= 1'b0;
            r_wr_ptr   <= '0;
            r_wr_ptr_c <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_acc) begin
                if (s_tlast) begin
                    if (w_bad) begin
                        // Rewind past the whole frame; reader never saw it
                        r_wr_ptr <= r_wr_ptr_c;
                        r_drop   <= 1'b0;
                    end else begin
                        r_wr_ptr   <= r_wr_ptr + ONE;
                        r_wr_ptr_c <= r_wr_ptr + ONE;
                    end
                end else if (w_bad) begin
                    r_drop <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + ONE;
                end
            end
        end
    end

`ifdef EGRESS_FIFO_DROP_COUNT_EN
    logic        w_drop_evt;
    logic [31:0] r_drop_cnt;

    assign w_drop_evt = w_acc && s_tlast && w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt && (r_drop_cnt != 32'hffff_ffff)) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_issue) begin
                        r_rd_ptr <= r_rd_ptr + ONE;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_word  <= r_ram_q;
                    r_state <= S_LO;
                end
                S_LO: begin
                    if (m_tready) begin
                        r_state <= w_hi_need ? S_HI : S_IDLE;
                    end
                end
                S_HI: begin
                    if (m_tready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rbm1    = r_word[67:64];
    assign w_rlast   = r_word[68];
    assign w_hi_need = w_rbm1 > 4'd3;
    assign w_unused  = ^r_word[71:69];

    // Outputs are pure functions of held state, so they stay stable under backpressure
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = 32'd0;
        m_tkeep  = 4'd0;
        m_tlast  = 1'b0;
        case (r_state)
            S_LO: begin
                m_tvalid = 1'b1;
                m_tdata  = r_word[31:0];
                m_tkeep  = (w_rbm1 >= 4'd3) ? 4'hf : (4'hf >> (4'd3 - w_rbm1));
                m_tlast  = w_rlast && (w_rbm1 <= 4'd3);
            end
            S_HI: begin
                m_tvalid = 1'b1;
                m_tdata  = r_word[63:32];
                m_tkeep  = 4'hf >> (4'd7 - w_rbm1);
                m_tlast  = w_rlast;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gigabit_egress_fifo.sv
// Directed bench for gigabit_egress_fifo (DEPTH=16): frame table plus latency,
// overflow, bad-keep, wrap and reset sequences.
module tb_gigabit_egress_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [31:0] drop_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_drops = 0;
    int rmode = 0;
    int rx_frames = 0;
    logic [36:0] rxq[$];

    typedef struct {
        int len;
        int seed;
        int bad;
        bit ok;
    } vec_t;

    vec_t tbl[9];

    gigabit_egress_fifo #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Port-side sink: sets m_tready per mode and logs every handshake
    always @(negedge clk) begin
        if (rmode == 2) m_tready = 1'($urandom_range(0, 1));
        else m_tready = (rmode == 1);
        if (m_tvalid && m_tready) begin
            rxq.push_back({m_tlast, m_tkeep, m_tdata});
            if (m_tlast) rx_frames++;
        end
    end

    function automatic logic [7:0] bv(input int seed, input int i);
        logic [31:0] v;
        v = 32'(seed * 37 + i * 5 + 1);
        return v[7:0];
    endfunction

    function automatic logic [31:0] exp_dc();
`ifdef EGRESS_FIFO_DROP_COUNT_EN
        return 32'(exp_drops);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
    endtask

    task automatic idle_in();
        s_tvalid = 1'b0;
        s_tdata  = 64'd0;
        s_tkeep  = 8'd0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int seed, input int bad);
        int nb;
        logic [63:0] d;
        logic [7:0] k;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = 64'd0;
            k = 8'd0;
            for (int l = 0; l < 8; l++) begin
                if (b * 8 + l < len) begin
                    d[8*l +: 8] = bv(seed, b * 8 + l);
                    k[l] = 1'b1;
                end
            end
            if (b == bad) k = 8'd0;
            drive_beat(d, k, b == nb - 1);
        end
        @(negedge clk);
        idle_in();
    endtask

    task automatic expect_frame(input int len, input int seed, input string nm);
        int need;
        int t;
        logic [36:0] e;
        logic [36:0] g;
        need = (len + 3) / 4;
        t = 0;
        while (rxq.size() < need && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " beats"}, 64'(rxq.size() >= need), 64'd1);
        for (int j = 0; j < need; j++) begin
            e = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * j + l < len) begin
                    e[8*l +: 8] = bv(seed, 4 * j + l);
                    e[32 + l] = 1'b1;
                end
            end
            e[36] = (j == need - 1);
            g = (rxq.size() > 0) ? rxq.pop_front() : 37'd0;
            chk($sformatf("%s beat%0d", nm, j), 64'(g), 64'(e));
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        chk({nm, " s_tready"}, 64'(s_tready), 64'd0);
        chk({nm, " m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({nm, " m_out"}, 64'({m_tlast, m_tkeep, m_tdata}), 64'd0);
        chk({nm, " drop_count"}, 64'(drop_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_drops = 0;
        repeat (2) @(negedge clk);
        chk({nm, " s_tready up"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        int t;
        int base;
        tbl[0] = '{61, 2, -1, 1'b1};
        tbl[1] = '{8, 3, -1, 1'b1};
        tbl[2] = '{4, 4, -1, 1'b1};
        tbl[3] = '{1, 5, -1, 1'b1};
        tbl[4] = '{24, 6, 1, 1'b0};
        tbl[5] = '{20, 7, -1, 1'b1};
        tbl[6] = '{16, 8, 1, 1'b0};
        tbl[7] = '{13, 9, -1, 1'b1};
        tbl[8] = '{64, 10, -1, 1'b1};

        rst = 1'b1;
        idle_in();
        do_reset("init");

        // 60-byte frame: latency then content
        rmode = 1;
        send_frame(60, 1, -1);
        chk("lat edge1", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("lat edge2", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("lat edge3", 64'(m_tvalid), 64'd1);
        expect_frame(60, 1, "f60");

        for (int v = 0; v < 9; v++) begin
            send_frame(tbl[v].len, tbl[v].seed, tbl[v].bad);
            if (tbl[v].ok) begin
                expect_frame(tbl[v].len, tbl[v].seed, $sformatf("vec%0d", v));
            end else begin
                exp_drops++;
                chk($sformatf("vec%0d drops", v), 64'(drop_count), 64'(exp_dc()));
                repeat (8) @(negedge clk);
                chk($sformatf("vec%0d silent", v), 64'(rxq.size()), 64'd0);
            end
        end

        // Overflow: 16-word frame fills the RAM, the 2-word one is dropped
        rmode = 0;
        repeat (2) @(negedge clk);
        send_frame(128, 20, -1);
        send_frame(16, 21, -1);
        exp_drops++;
        chk("ovf drops", 64'(drop_count), 64'(exp_dc()));
        chk("ovf stalled", 64'(m_tvalid), 64'd1);
        chk("ovf none yet", 64'(rxq.size()), 64'd0);
        rmode = 1;
        expect_frame(128, 20, "ovf f16w");
        repeat (12) @(negedge clk);
        chk("ovf no 2nd", 64'(rxq.size()), 64'd0);

        // Wrap: 40 paced 3-word frames with random port ready
        rmode = 2;
        base = rx_frames;
        for (int k = 0; k < 40; k++) begin
            t = 0;
            while (k - (rx_frames - base) > 4 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) chk("wrap pacing", 64'd1, 64'd0);
            send_frame(24, 100 + k, -1);
        end
        for (int k = 0; k < 40; k++) begin
            expect_frame(24, 100 + k, $sformatf("wrap%0d", k));
        end
        chk("wrap drops", 64'(drop_count), 64'(exp_dc()));

        // Reset with a committed frame stalled and a partial frame in flight
        rmode = 0;
        repeat (4) @(negedge clk);
        send_frame(40, 30, -1);
        drive_beat(64'h1122334455667788, 8'hff, 1'b0);
        drive_beat(64'h99aabbccddeeff00, 8'hff, 1'b0);
        chk("pre-rst stalled", 64'(m_tvalid), 64'd1);
        do_reset("midrst");
        rmode = 1;
        repeat (10) @(negedge clk);
        chk("midrst flushed", 64'(rxq.size()), 64'd0);
        send_frame(33, 31, -1);
        expect_frame(33, 31, "post-rst");
        chk("post-rst drops", 64'(drop_count), 64'(exp_dc()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
